// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage: BOOT/RUN sequencing, sequential fetch, jump flush.
// Optional stall support is compiled in with the FETCH_STALL_EN macro.
module pc_fetch_unit #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_mux_sel,
    input  logic [ADDR_W-1:0] jmp_loc,
    input  logic              stall,
    input  logic [DATA_W-1:0] imem_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] ins,
    output logic [ADDR_W-1:0] current_address,
    output logic              ins_valid
);

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              hold;

    // Wraps naturally at 2**ADDR_W; no overflow indication is wanted.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur);
        return cur + ADDR_W'(1);
    endfunction

`ifdef FETCH_STALL_EN
    assign hold = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign hold         = 1'b0;
`endif

    assign imem_addr = pc;

    // Fetch stage: jump beats stall, stall beats sequential fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= BOOT;
            pc              <= '0;
            ins             <= '0;
            current_address <= '0;
            ins_valid       <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state     <= RUN;
                    pc        <= '0;
                    ins       <= '0;
                    ins_valid <= 1'b0;
                end
                default: begin
                    if (pc_mux_sel) begin
                        pc              <= jmp_loc;
                        ins             <= '0;
                        ins_valid       <= 1'b0;
                        current_address <= pc;
                    end else if (!hold) begin
                        pc              <= next_pc(pc);
                        ins             <= imem_data;
                        ins_valid       <= 1'b1;
                        current_address <= pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed boot/wrap/jump/stall/reset
// scenarios followed by randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_mux_sel;
    logic [7:0]  jmp_loc;
    logic        stall;
    logic [19:0] imem_data;
    logic [7:0]  imem_addr;
    logic [19:0] ins;
    logic [7:0]  current_address;
    logic        ins_valid;

    logic [19:0] mem [256];

    int total = 0;
    int bad   = 0;

`ifdef FETCH_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    // Reference state: what the fetch stage should present after each edge.
    bit          m_boot;
    logic [7:0]  m_pc;
    logic [19:0] m_ins;
    logic [7:0]  m_ca;
    logic        m_vld;

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_mux_sel      (pc_mux_sel),
        .jmp_loc         (jmp_loc),
        .stall           (stall),
        .imem_data       (imem_data),
        .imem_addr       (imem_addr),
        .ins             (ins),
        .current_address (current_address),
        .ins_valid       (ins_valid)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = 8'h00;
        m_ins  = 20'h00000;
        m_ca   = 8'h00;
        m_vld  = 1'b0;
    endtask

    // One clock edge worth of fetch behaviour, stated as transactions.
    task automatic model_edge(input logic jmp, input logic [7:0] loc, input logic stl);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (jmp) begin
            m_ca  = m_pc;
            m_pc  = loc;
            m_ins = 20'h00000;
            m_vld = 1'b0;
        end else if (!(STALL_EN && stl)) begin
            m_ins = mem[m_pc];
            m_ca  = m_pc;
            m_vld = 1'b1;
            m_pc  = 8'((int'(m_pc) + 1) % 256);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".addr"},  32'(imem_addr),       32'(m_pc));
        check_val({tag, ".ins"},   32'(ins),             32'(m_ins));
        check_val({tag, ".ca"},    32'(current_address), 32'(m_ca));
        check_val({tag, ".vld"},   32'(ins_valid),       32'(m_vld));
    endtask

    task automatic step(input string tag, input logic jmp, input logic [7:0] loc, input logic stl);
        pc_mux_sel = jmp;
        jmp_loc    = loc;
        stall      = stl;
        @(posedge clk);
        model_edge(jmp, loc, stl);
        #1;
        check_all(tag);
    endtask

    // Called 1 time unit after an edge: pulse reset between edges, then release.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all({tag, ".imm"});
        #45 check_all({tag, ".hold"});
        #4 reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 20'($urandom);
        mem[0]     = 20'h12345;
        reset      = 1'b1;
        pc_mux_sel = 1'b0;
        jmp_loc    = 8'h00;
        stall      = 1'b0;
        model_reset();

        #100;
        check_all("rst");
        check_val("rst.ins_const", 32'(ins), 32'h0);
        #100 reset = 1'b0;

        // Boot: first edge only leaves BOOT, second edge fetches address 0.
        step("boot1", 1'b0, 8'h00, 1'b0);
        check_val("boot1.vld_const", 32'(ins_valid), 32'h0);
        step("boot2", 1'b0, 8'h00, 1'b0);
        check_val("boot2.ins_const", 32'(ins), 32'h12345);
        check_val("boot2.addr_const", 32'(imem_addr), 32'h01);

        // Wrap through FF -> 00.
        step("wrap.j", 1'b1, 8'hFE, 1'b0);
        check_val("wrap.fe", 32'(imem_addr), 32'hFE);
        step("wrap1", 1'b0, 8'h00, 1'b0);
        check_val("wrap.ff", 32'(imem_addr), 32'hFF);
        step("wrap2", 1'b0, 8'h00, 1'b0);
        check_val("wrap.00", 32'(imem_addr), 32'h00);
        check_val("wrap.ca_ff", 32'(current_address), 32'hFF);
        step("wrap3", 1'b0, 8'h00, 1'b0);
        check_val("wrap.01", 32'(imem_addr), 32'h01);

        // Jump flush from PC=04 to 20.
        step("jf.to04", 1'b1, 8'h04, 1'b0);
        step("jf.j", 1'b1, 8'h20, 1'b0);
        check_val("jf.bubble", 32'(ins_valid), 32'h0);
        check_val("jf.addr20", 32'(imem_addr), 32'h20);
        step("jf.fetch", 1'b0, 8'h00, 1'b0);
        check_val("jf.ins20", 32'(ins), 32'(mem[8'h20]));
        check_val("jf.ca20", 32'(current_address), 32'h20);

        // Stall for three edges at PC=10.
        step("st.to10", 1'b1, 8'h10, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step("st.hold", 1'b0, 8'h00, 1'b1);
            check_val("st.addr", 32'(imem_addr), STALL_EN ? 32'h10 : 32'(8'h10 + i));
        end
        step("st.rel", 1'b0, 8'h00, 1'b0);

        // Jump wins over stall; back-to-back jumps; jump to self.
        step("js", 1'b1, 8'h08, 1'b1);
        check_val("js.addr08", 32'(imem_addr), 32'h08);
        check_val("js.vld", 32'(ins_valid), 32'h0);
        step("bb1", 1'b1, 8'h40, 1'b0);
        step("bb2", 1'b1, 8'h41, 1'b0);
        step("self", 1'b1, 8'h41, 1'b0);
        step("self.re", 1'b0, 8'h00, 1'b0);
        check_val("self.ca", 32'(current_address), 32'h41);

        // Asynchronous reset mid-run at PC=33.
        step("ar.to33", 1'b1, 8'h33, 1'b0);
        step("ar.run", 1'b0, 8'h00, 1'b1);
        reset_pulse("ar");
        step("ar.boot1", 1'b0, 8'h00, 1'b0);
        step("ar.boot2", 1'b0, 8'h00, 1'b0);
        check_val("ar.ins", 32'(ins), 32'h12345);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset_pulse("rnd.rst");
            end else begin
                step("rnd", ($urandom_range(0, 7) == 0), 8'($urandom),
                     ($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 The block SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_mux_sel  in  1  jump request from the jump-control stage; 1 selects jmp_loc as the next PC.
- jmp_loc  in  8  jump target address.
- stall  in  1  hold request from downstream; 1 freezes fetch.
- imem_data  in  20  instruction word read combinationally from imem_addr.
- imem_addr  out  8  instruction-memory address; always equals the internal PC.
- ins  out  20  fetched instruction register.
- current_address  out  8  address of the instruction currently held in ins.
- ins_valid  out  1  1 = ins holds a real fetched instruction; 0 = NOP bubble.

Function
REQ-003 The block SHALL hold an 8-bit PC register, and imem_addr SHALL equal PC combinationally.
REQ-004 The block SHALL implement a two-state FSM: BOOT and RUN.
- BOOT: entered on reset.
- BOOT -> RUN on the first rising edge after reset deassertion.
- In BOOT, PC holds 0, ins holds 20'h00000 and ins_valid holds 0.
REQ-005 In RUN, on each rising edge with stall=0 and pc_mux_sel=0, the block SHALL load:
- ins <= imem_data;
- current_address <= PC;
- ins_valid <= 1;
- PC <= PC+1.
REQ-006 In RUN, on a rising edge with pc_mux_sel=1, the block SHALL load:
- PC <= jmp_loc;
- ins <= 20'h00000 (flush bubble);
- ins_valid <= 0;
- current_address <= PC.
REQ-007 pc_mux_sel=1 SHALL take priority over stall; the jump SHALL be taken even when stall=1.
REQ-008 Fetch latency SHALL be one cycle: the word at address A SHALL appear on ins on the edge that ends the cycle in which PC==A.
REQ-009 PC increment SHALL be modulo 256, so 8'hFF+1 = 8'h00 with no flag and no stop.
REQ-010 A jmp_loc equal to the current PC SHALL be legal and SHALL produce a bubble followed by a refetch of the same address.
REQ-011 Back-to-back pc_mux_sel pulses SHALL each redirect the PC, and ins_valid SHALL stay 0 for every redirect cycle.

Reset
REQ-012 Assertion of reset SHALL immediately, with no clock edge required, force:
- PC=8'h00, ins=20'h00000, current_address=8'h00, ins_valid=0;
- FSM state = BOOT.
REQ-013 Reset asserted mid-operation, including during stall or on a jump cycle, SHALL override all other inputs.
REQ-014 While reset=1 all outputs SHALL hold their reset values.

Configuration
REQ-015 The macro FETCH_STALL_EN SHALL control the stall feature.
- Defined: stall behaves per REQ-016.
- Undefined: the stall port SHALL still exist but SHALL be ignored, and the block SHALL behave as if stall=0.
REQ-016 With FETCH_STALL_EN defined, in RUN with stall=1 and pc_mux_sel=0, PC, ins, current_address and ins_valid SHALL all hold their values.

Verification
REQ-017 Reset/boot: reset=1 at 0 ns, released at 200 ns, imem_data=20'h12345 at address 0.
- During reset: imem_addr=00, ins=00000, ins_valid=0.
- First edge after release: BOOT only, ins_valid=0.
- Second edge: ins=12345, current_address=00, ins_valid=1, imem_addr=01.
REQ-018 Sequential fetch and wrap: PC preloaded to FE by jump, then 3 free-running edges.
- imem_addr SHALL step FE, FF, 00, 01.
- current_address SHALL follow one cycle behind.
REQ-019 Jump flush: at PC=04, pc_mux_sel=1, jmp_loc=8'h20 for one edge.
- That edge: ins=00000, ins_valid=0, imem_addr=20.
- Next edge: ins=imem[20], current_address=20, ins_valid=1.
REQ-020 Stall with FETCH_STALL_EN defined: stall=1 for 3 edges at PC=10.
- PC, ins and current_address SHALL remain unchanged.
- On release, fetch SHALL resume at 10.
- Without the macro, the same stimulus SHALL give PC 11, 12, 13.
REQ-021 Jump during stall: stall=1, pc_mux_sel=1, jmp_loc=8'h08.
- PC SHALL become 08 and ins_valid SHALL be 0.
REQ-022 Asynchronous reset mid-run: reset pulsed high for 50 ns between edges at PC=33.
- Outputs SHALL go to reset values within the pulse, with no clock edge.
- The BOOT sequence of REQ-017 SHALL repeat after release.
